// File: rtl/oc8051_symbolic_rom_cache.sv
// Symbolic code-ROM: each byte address binds to the free word_in lane on first fetch, then replays it.
// Latency: rd_data/rd_valid registered, 1 cycle after rd_req; PC query outputs are combinational.
// Backpressure: none; a fetch is accepted every cycle, and lock/flush only gate binding.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   word_in               unconstrained fetch data, lane i = bits [8i+7:8i]
//   rd_req, rd_addr       fetch request and byte address
//   rd_valid, rd_data     registered response
//   flush, lock           invalidate-all, and freeze (no new bindings)
//   miss_err              sticky: invalid byte fetched while locked
//   fill_count            number of bound entries
//   pc_q                  NPC query addresses, port k = bits [AW*k+AW-1:AW*k]
//   op_valid, op_out      all query windows bound, and the byte at pc_q port 0
module oc8051_symbolic_rom_cache #(
  parameter int IDX_W = 4,
  parameter int LANES = 4,
  parameter int NPC   = 2,
  parameter int AW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] word_in,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [8*LANES-1:0] rd_data,
  input  logic               flush,
  input  logic               lock,
  output logic               miss_err,
  output logic [IDX_W:0]     fill_count,
  input  logic [NPC*AW-1:0]  pc_q,
  output logic               op_valid,
  output logic [7:0]         op_out
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]   r_valid;
  logic [7:0]         r_mem [DEPTH];
  logic               r_rd_valid;
  logic [8*LANES-1:0] r_rd_data;
  logic               r_miss_err;
  logic [IDX_W:0]     r_fill_count;

  logic [IDX_W-1:0]   w_idx [LANES];
  logic [8*LANES-1:0] w_resp;
  logic               w_bind;
  logic               w_miss;
  logic [DEPTH-1:0]   w_valid_nxt;
  logic [IDX_W:0]     w_fill_nxt;
  logic [IDX_W-1:0]   w_q0_idx;
  logic               w_unused;

  // Only the low IDX_W address bits select an entry; upper bits alias.
  assign w_unused = ^{rd_addr, pc_q};

  // Flush beats a same-cycle bind; lock suppresses binding entirely.
  assign w_bind = rd_req && !lock && !flush;

  // Lane indices wrap modulo DEPTH through the IDX_W-bit addition.
  always_comb begin
    w_resp = '0;
    w_miss = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_idx[i] = rd_addr[IDX_W-1:0] + IDX_W'(i);
      if (r_valid[w_idx[i]]) begin
        w_resp[8*i +: 8] = r_mem[w_idx[i]];
      end else begin
        w_resp[8*i +: 8] = word_in[8*i +: 8];
        w_miss = w_miss | (rd_req && lock);
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    if (flush) begin
      w_valid_nxt = '0;
    end else if (w_bind) begin
      for (int i = 0; i < LANES; i++) begin
        w_valid_nxt[w_idx[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_fill_nxt = '0;
    for (int d = 0; d < DEPTH; d++) begin
      w_fill_nxt = w_fill_nxt + (IDX_W+1)'(w_valid_nxt[d]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_miss_err   <= 1'b0;
      r_fill_count <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_fill_count <= w_fill_nxt;
      r_rd_valid   <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_resp;
      end
      // Flush wins over a same-cycle locked miss.
      r_miss_err <= flush ? 1'b0 : (r_miss_err | w_miss);
    end
  end

  // Byte storage carries no reset; validity lives in r_valid only.
  always_ff @(posedge clk) begin
    if (!rst && w_bind) begin
      for (int i = 0; i < LANES; i++) begin
        if (!r_valid[w_idx[i]]) begin
          r_mem[w_idx[i]] <= word_in[8*i +: 8];
        end
      end
    end
  end

  // PC window query on the current registered state.
  always_comb begin
    logic [IDX_W-1:0] v_base;
    logic [IDX_W-1:0] v_ent;
    op_valid = 1'b1;
    v_base   = '0;
    v_ent    = '0;
    for (int k = 0; k < NPC; k++) begin
      v_base = pc_q[AW*k +: IDX_W];
      for (int j = 0; j < LANES; j++) begin
        v_ent = v_base + IDX_W'(j);
        op_valid = op_valid & r_valid[v_ent];
      end
    end
  end

  assign w_q0_idx = pc_q[IDX_W-1:0];
  assign op_out   = r_valid[w_q0_idx] ? r_mem[w_q0_idx] : 8'h00;

  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign miss_err   = r_miss_err;
  assign fill_count = r_fill_count;

endmodule

// File: tb/tb_oc8051_symbolic_rom_cache.sv
// Directed bench for oc8051_symbolic_rom_cache (DEPTH=16, LANES=4, NPC=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge.
// Expected values are hand-computed constants for each directed step.
module tb_oc8051_symbolic_rom_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        flush;
  logic        lock;
  logic        miss_err;
  logic [4:0]  fill_count;
  logic [31:0] pc_q;
  logic        op_valid;
  logic [7:0]  op_out;

  int tests  = 0;
  int failed = 0;

  oc8051_symbolic_rom_cache #(.IDX_W(4), .LANES(4), .NPC(2), .AW(16)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .flush(flush), .lock(lock),
    .miss_err(miss_err), .fill_count(fill_count), .pc_q(pc_q),
    .op_valid(op_valid), .op_out(op_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [15:0] a, input logic [31:0] w);
    rd_req  = 1'b1;
    rd_addr = a;
    word_in = w;
    tick();
    rd_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; word_in = '0; rd_req = 1'b0; rd_addr = '0;
    flush = 1'b0; lock = 1'b0; pc_q = '0;
    tick();
    tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_miss", 32'(miss_err), 32'd0);
    rst = 1'b0;

    // 1: first bind
    req(16'h0000, 32'h44332211);
    chk("t1_rd_valid", 32'(rd_valid), 32'd1);
    chk("t1_rd_data", rd_data, 32'h44332211);
    chk("t1_fill", 32'(fill_count), 32'd4);
    tick();
    chk("t1_idle_valid", 32'(rd_valid), 32'd0);
    chk("t1_idle_hold", rd_data, 32'h44332211);

    // 2: no rebind, partial overlap
    req(16'h0000, 32'hDEADBEEF);
    chk("t2_rebind_data", rd_data, 32'h44332211);
    chk("t2_rebind_fill", 32'(fill_count), 32'd4);
    req(16'h0002, 32'hAABBCCDD);
    chk("t2_overlap_data", rd_data, 32'hAABB4433);
    chk("t2_overlap_fill", 32'(fill_count), 32'd6);

    // 3: index wrap with aliased upper address bits
    req(16'h100E, 32'h11223344);
    chk("t3_wrap_data", rd_data, 32'h22113344);
    chk("t3_wrap_fill", 32'(fill_count), 32'd8);

    // 4: PC window query
    pc_q = {16'h000E, 16'h0000};
    #1;
    chk("t4_op_valid", 32'(op_valid), 32'd1);
    chk("t4_op_out", 32'(op_out), 32'h11);
    pc_q = {16'h0006, 16'h0000};
    #1;
    chk("t4_op_valid_hole", 32'(op_valid), 32'd0);
    pc_q = {16'h0006, 16'h0008};
    #1;
    chk("t4_op_out_unbound", 32'(op_out), 32'h00);

    // 5: lock
    lock = 1'b1;
    req(16'h0008, 32'h55667788);
    chk("t5_lock_data", rd_data, 32'h55667788);
    chk("t5_lock_miss", 32'(miss_err), 32'd1);
    chk("t5_lock_fill", 32'(fill_count), 32'd8);
    req(16'h0008, 32'h01020304);
    chk("t5_lock_reread", rd_data, 32'h01020304);
    req(16'h0000, 32'h0);
    chk("t5_lock_hit_data", rd_data, 32'h44332211);
    chk("t5_miss_sticky", 32'(miss_err), 32'd1);

    // 6: flush with a same-cycle locked miss: flush wins
    flush = 1'b1;
    req(16'h0008, 32'h0BADF00D);
    flush = 1'b0;
    chk("t6_flush_lock_miss", 32'(miss_err), 32'd0);
    chk("t6_flush_lock_fill", 32'(fill_count), 32'd0);

    // Refill a few entries, then flush with a same-cycle request
    lock = 1'b0;
    req(16'h0000, 32'h44332211);
    chk("t6_refill", 32'(fill_count), 32'd4);
    lock = 1'b1;
    req(16'h0008, 32'h0);
    chk("t6_miss_again", 32'(miss_err), 32'd1);
    lock = 1'b0;
    flush = 1'b1;
    req(16'h0000, 32'h99999999);
    flush = 1'b0;
    chk("t6_flush_data", rd_data, 32'h44332211);
    chk("t6_flush_fill", 32'(fill_count), 32'd0);
    chk("t6_flush_miss", 32'(miss_err), 32'd0);
    pc_q = {16'h0000, 16'h0000};
    #1;
    chk("t6_flush_op_valid", 32'(op_valid), 32'd0);
    req(16'h0000, 32'h0A0B0C0D);
    chk("t6_rebind_data", rd_data, 32'h0A0B0C0D);
    chk("t6_rebind_fill", 32'(fill_count), 32'd4);
    chk("t6_rebind_op_out", 32'(op_out), 32'h0D);
    chk("t6_rebind_op_valid", 32'(op_valid), 32'd1);

    // Reset with a request in the same cycle: no response, all state cleared
    lock = 1'b1;
    req(16'h0008, 32'h0);
    chk("t6_pre_rst_miss", 32'(miss_err), 32'd1);
    lock = 1'b0;
    rst = 1'b1;
    req(16'h0004, 32'h12345678);
    rst = 1'b0;
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'h0);
    chk("t6_rst_fill", 32'(fill_count), 32'd0);
    chk("t6_rst_miss", 32'(miss_err), 32'd0);
    chk("t6_rst_op_out", 32'(op_out), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/oc8051_symbolic_rom_cache.md
Name: oc8051_symbolic_rom_cache

Overview:
- Parametrised symbolic code-ROM model for 8051 formal and simulation benches.
- Each byte address binds to a free symbolic value (`word_in` lane) on first fetch and returns that same byte on every later fetch, so code memory stays consistent without a concrete image.
- Adds to the previous generation:
  - configurable depth, lanes and PC-query count;
  - registered 1-cycle read response;
  - flush and lock modes, sticky miss detection, fill counter.
- Sits between the core's code-fetch port and the unconstrained input driver.

Parameters:
- IDX_W, 4, index bits; DEPTH = 2^IDX_W bytes tracked.
- LANES, 4, bytes per fetch word; legal range 1 <= LANES <= DEPTH.
- NPC, 2, number of PC-window query ports; must be >= 1.
- AW, 16, code address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- word_in  in  8*LANES  symbolic fetch data; lane i = bits [8i+7:8i]
- rd_req  in  1  fetch request this cycle
- rd_addr  in  AW  fetch byte address
- rd_valid  out  1  response valid, one cycle after rd_req
- rd_data  out  8*LANES  registered response word
- flush  in  1  invalidate all entries
- lock  in  1  freeze: no new bindings
- miss_err  out  1  sticky: invalid byte fetched while locked
- fill_count  out  IDX_W+1  number of valid entries
- pc_q  in  NPC*AW  PC query addresses; port k = bits [AW*k+AW-1:AW*k]
- op_valid  out  1  every query window fully bound
- op_out  out  8  byte at pc_q port 0 index, else 0

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
  - Reset clears all valid bits, rd_valid, rd_data, miss_err and fill_count to 0.
  - Byte storage is not reset.
  - rst has priority over every other input, including mid-request: a request in the reset cycle produces no response.
- Lane index: idx_i = (rd_addr[IDX_W-1:0] + i) mod DEPTH. Wrap-around is required.
- Read path (rd_req=1):
  - Per lane, resp_i = valid[idx_i] ? mem[idx_i] : word_in lane i, evaluated on pre-edge state.
  - rd_data <= {resp_LANES-1 .. resp_0}; rd_valid <= 1.
  - When rd_req=0: rd_valid <= 0 and rd_data holds its value.
- Bind: on rd_req with lock=0 and flush=0, each invalid lane writes mem[idx_i] <= word_in lane i and sets valid[idx_i] <= 1.
- Lock:
  - lock=1 suppresses all binds.
  - Any rd_req lane hitting an invalid entry returns word_in for that lane and sets miss_err <= 1.
  - miss_err clears only on rst or flush.
- Flush:
  - Clears every valid bit and miss_err at the edge.
  - Has priority over a same-cycle bind: that request still responds from pre-flush state, but nothing is bound.
  - A same-cycle lock=1 miss does not set miss_err (flush wins).
- fill_count:
  - Registered; equals the popcount of the valid bits after the edge.
  - Saturation is impossible (max DEPTH).
  - 0 after flush or rst.
- PC query (combinational on current registered state):
  - Window k is valid when all entries (pc_q[k][IDX_W-1:0] + j) mod DEPTH are valid, for j = 0..LANES-1.
  - op_valid is the AND of all windows.
  - op_out = valid[pc_q0 index] ? mem[pc_q0 index] : 8'h00.
- Binding is first-touch only: a bound byte never changes except through flush followed by rebind.

Test Plan:
(DEPTH=16, LANES=4, NPC=2 unless noted)
1. After rst, rd_req addr 0x0000, word_in 0x44332211 -> next cycle rd_valid=1, rd_data=0x44332211, fill_count=4. Idle cycle after -> rd_valid=0, rd_data held.
2. rd_req addr 0x0000, word_in 0xDEADBEEF -> rd_data=0x44332211, fill_count=4 (no rebind). Then addr 0x0002, word_in 0xAABBCCDD -> rd_data=0xAABB4433, fill_count=6.
3. Wrap: rd_req addr 0x100E, word_in 0x11223344 -> rd_data=0x22113344, fill_count=8.
4. pc_q0=0x0000, pc_q1=0x000E -> op_valid=1, op_out=0x11. Set pc_q1=0x0006 -> op_valid=0. Set pc_q0=0x0008 -> op_out=0x00.
5. lock=1, rd_req addr 0x0008, word_in 0x55667788 -> rd_data=0x55667788, miss_err=1, fill_count=8. Re-read with word_in 0x01020304 -> rd_data=0x01020304.
6. flush=1 together with rd_req addr 0x0000, word_in 0x99999999 -> rd_data=0x44332211, fill_count=0, miss_err=0. Next read of addr 0x0000 with lock=0 binds the new word_in. Assert rst mid-sequence -> all outputs 0 on the next cycle.
